envelope_sequencer_multi: RTL and testbench

//   Multi-channel, ROM-table-driven volume envelope sequencer; successor to the single-channel

---
 rtl/envelope_sequencer_multi.sv | 191 +++++++++++++++++++
 tb/tb_envelope_sequencer_multi.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/envelope_sequencer_multi.sv
`default_nettype none
// ============================================================================
// Module   : envelope_sequencer_multi
// Brief    : Time-multiplexed, ROM-table-driven volume envelope sequencer for
//            NUM_CH channels sharing one synchronous instrument ROM.
// Revision : 1.0 - initial release
// ============================================================================
module envelope_sequencer_multi #(
  parameter int NUM_CH     = 4,
  parameter int AMP_W      = 4,
  parameter int INST_W     = 4,
  parameter int STEPS_LOG2 = 4,
  parameter int DUR_W      = 6
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_CH-1:0]             i_load_instrument,
  input  logic [NUM_CH*INST_W-1:0]      i_instrument,
  input  logic [NUM_CH-1:0]             i_key_off,
  input  logic                          i_strobe,
  output logic                          o_busy,
  output logic                          o_valid,
  output logic [NUM_CH*AMP_W-1:0]       o_amplitude,
  output logic [INST_W+STEPS_LOG2-1:0]  o_rom_addr,
  input  logic [15:0]                   i_rom_data
);

  localparam int         c_ch_w      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] c_op_step   = 2'b00;
  localparam logic [1:0] c_op_sustain = 2'b01;
  localparam logic [1:0] c_op_end    = 2'b10;
  localparam logic [1:0] c_op_jump   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_WAIT  = 3'd2,
    S_APPLY = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [c_ch_w-1:0]             r_ch;
  logic                          r_pending;
  logic                          r_stale;
  logic [INST_W+STEPS_LOG2-1:0]  r_rom_addr;

  logic                          r_active [NUM_CH];
  logic                          r_rel    [NUM_CH];
  logic                          r_sus    [NUM_CH];
  logic [STEPS_LOG2-1:0]         r_step   [NUM_CH];
  logic [DUR_W-1:0]              r_cnt    [NUM_CH];
  logic [INST_W-1:0]             r_inst   [NUM_CH];
  logic [AMP_W-1:0]              r_amp    [NUM_CH];

  logic                          w_fetch;
  logic                          w_last;
  logic [1:0]                    w_op;
  logic [DUR_W-1:0]              w_dur;
  logic [DUR_W-1:0]              w_dur1;
  logic [AMP_W-1:0]              w_amp;
  logic [STEPS_LOG2-1:0]         w_tgt;
  logic                          w_unused;

  assign w_op     = i_rom_data[15:14];
  assign w_dur    = i_rom_data[8 +: DUR_W];
  assign w_dur1   = (w_dur == '0) ? DUR_W'(1) : w_dur;
  assign w_amp    = i_rom_data[0 +: AMP_W];
  assign w_tgt    = i_rom_data[8 +: STEPS_LOG2];
  assign w_unused = ^i_rom_data;

  assign o_busy     = (r_state != S_IDLE);
  assign o_valid    = (r_state == S_DONE);
  assign o_rom_addr = r_rom_addr;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_amp_pack
      assign o_amplitude[g*AMP_W +: AMP_W] = r_amp[g];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // A channel is fetched when active, not parked on an unreleased sustain,
  // and its hold counter has run down to 0 or 1.
  always_comb begin
    w_next  = r_state;
    w_fetch = 1'b0;
    w_last  = (r_ch == c_ch_w'(NUM_CH - 1));
    case (r_state)
      S_IDLE:  if (i_strobe || r_pending) w_next = S_SCAN;
      S_SCAN: begin
        w_fetch = r_active[r_ch] && !(r_sus[r_ch] && !r_rel[r_ch]) &&
                  (r_cnt[r_ch] <= DUR_W'(1));
        if (w_fetch)     w_next = S_WAIT;
        else if (w_last) w_next = S_DONE;
      end
      S_WAIT:  w_next = S_APPLY;
      S_APPLY: w_next = w_last ? S_DONE : S_SCAN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ch       <= '0;
      r_pending  <= 1'b0;
      r_stale    <= 1'b0;
      r_rom_addr <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_active[c] <= 1'b0;
        r_rel[c]    <= 1'b0;
        r_sus[c]    <= 1'b0;
        r_step[c]   <= '0;
        r_cnt[c]    <= '0;
        r_inst[c]   <= '0;
        r_amp[c]    <= '0;
      end
    end else begin
      if (r_state != S_IDLE && i_strobe)
        r_pending <= 1'b1;
      else if (r_state == S_IDLE && (i_strobe || r_pending))
        r_pending <= 1'b0;

      case (r_state)
        S_IDLE:  r_ch <= '0;
        S_SCAN: begin
          r_stale <= i_load_instrument[r_ch];
          if (w_fetch) r_rom_addr <= {r_inst[r_ch], r_step[r_ch]};
          else         r_ch <= r_ch + 1'b1;
        end
        S_WAIT:  r_stale <= r_stale | i_load_instrument[r_ch];
        S_APPLY: r_ch <= r_ch + 1'b1;
        default: ;
      endcase

      // Load has priority over both the countdown and an in-flight apply.
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_load_instrument[c]) begin
          r_active[c] <= 1'b1;
          r_rel[c]    <= 1'b0;
          r_sus[c]    <= 1'b0;
          r_step[c]   <= '0;
          r_cnt[c]    <= '0;
          r_amp[c]    <= '0;
          r_inst[c]   <= i_instrument[c*INST_W +: INST_W];
        end else begin
          if (i_key_off[c] && r_active[c]) r_rel[c] <= 1'b1;
          if (r_state == S_SCAN && r_ch == c_ch_w'(c) && !w_fetch &&
              r_active[c] && !(r_sus[c] && !r_rel[c]))
            r_cnt[c] <= r_cnt[c] - 1'b1;
          if (r_state == S_APPLY && r_ch == c_ch_w'(c) && !r_stale) begin
            case (w_op)
              c_op_step: begin
                r_amp[c]  <= w_amp;
                r_step[c] <= r_step[c] + 1'b1;
                r_cnt[c]  <= w_dur1;
                r_sus[c]  <= 1'b0;
              end
              c_op_sustain: begin
                r_amp[c]  <= w_amp;
                r_step[c] <= r_step[c] + 1'b1;
                r_cnt[c]  <= w_dur1;
                r_sus[c]  <= 1'b1;
              end
              c_op_end: begin
                r_amp[c]    <= w_amp;
                r_active[c] <= 1'b0;
                r_sus[c]    <= 1'b0;
              end
              default: begin
                r_step[c] <= w_tgt;
                r_cnt[c]  <= DUR_W'(1);
                r_sus[c]  <= 1'b0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_envelope_sequencer_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_envelope_sequencer_multi
// Brief    : Scoreboard bench for envelope_sequencer_multi with a ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_envelope_sequencer_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  load = '0;
  logic [15:0] instrument = '0;
  logic [3:0]  key_off = '0;
  logic        strobe = 1'b0;
  logic        busy;
  logic        valid;
  logic [15:0] amplitude;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data = '0;

  logic [15:0] rom [256];
  logic [15:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          valid_cnt = 0;
  int          lat;
  int          base;

  envelope_sequencer_multi dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_load_instrument (load),
    .i_instrument      (instrument),
    .i_key_off         (key_off),
    .i_strobe          (strobe),
    .o_busy            (busy),
    .o_valid           (valid),
    .o_amplitude       (amplitude),
    .o_rom_addr        (rom_addr),
    .i_rom_data        (rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] op, input logic [5:0] dur, input logic [3:0] amp);
    return {op, dur, 4'h0, amp};
  endfunction

  // Each completed sweep is matched against the oldest expected amplitude vector.
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) check_val("sb_underflow", {31'd0, valid}, 32'd0);
      else check_val("sb_amp", {16'd0, amplitude}, {16'd0, exp_q.pop_front()});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_ch(input int ch, input logic [3:0] inst, input logic koff);
    @(negedge clk);
    load[ch] = 1'b1;
    key_off[ch] = koff;
    instrument[ch*4 +: 4] = inst;
    @(negedge clk);
    load = '0;
    key_off = '0;
  endtask

  task automatic release_ch(input int ch);
    @(negedge clk);
    key_off[ch] = 1'b1;
    @(negedge clk);
    key_off = '0;
  endtask

  task automatic sweep(input logic [15:0] exp_amp, output int n);
    exp_q.push_back(exp_amp);
    @(negedge clk);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    check_val("busy_in_sweep", {31'd0, busy}, 32'd1);
    n = 1;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("sweep_done", {31'd0, valid}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h20] = mk(2'd0, 6'd3, 4'd15);
    rom[8'h21] = mk(2'd2, 6'd0, 4'd4);
    rom[8'h10] = mk(2'd1, 6'd0, 4'd9);
    rom[8'h11] = mk(2'd0, 6'd1, 4'd2);
    rom[8'h30] = mk(2'd0, 6'd1, 4'd7);
    rom[8'h31] = mk(2'd3, 6'd0, 4'd5);
    rom[8'h40] = mk(2'd0, 6'd1, 4'd10);
    rom[8'h50] = mk(2'd0, 6'd1, 4'd3);
    for (int i = 0; i < 16; i++) rom[8'(8'h60 + i)] = mk(2'd0, 6'd1, 4'(15 - i));

    do_reset();
    check_val("rst_amp", {16'd0, amplitude}, 32'd0);
    check_val("rst_valid", {31'd0, valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_addr", {24'd0, rom_addr}, 32'd0);

    // Idle sweep: no channel active, one cycle per channel plus DONE.
    sweep(16'h0000, lat);
    check_val("t1_latency", lat, 32'd5);
    check_val("t1_addr", {24'd0, rom_addr}, 32'd0);

    // STEP with hold 3 then END.
    load_ch(0, 4'd2, 1'b0);
    for (int k = 0; k < 3; k++) sweep(16'h000F, lat);
    sweep(16'h0004, lat);
    sweep(16'h0004, lat);
    check_val("t2_addr", {24'd0, rom_addr}, 32'h21);
    check_val("t2_idle_latency", lat, 32'd5);

    // SUSTAIN until key-off; load with simultaneous key-off must not release.
    do_reset();
    load_ch(1, 4'd1, 1'b1);
    for (int k = 0; k < 5; k++) sweep(16'h0090, lat);
    release_ch(1);
    sweep(16'h0020, lat);
    check_val("t3_addr", {24'd0, rom_addr}, 32'h11);

    // JUMP loop.
    do_reset();
    load_ch(2, 4'd3, 1'b0);
    sweep(16'h0700, lat);
    check_val("t4_addr1", {24'd0, rom_addr}, 32'h30);
    sweep(16'h0700, lat);
    check_val("t4_addr2", {24'd0, rom_addr}, 32'h31);
    sweep(16'h0700, lat);
    check_val("t4_addr3", {24'd0, rom_addr}, 32'h30);

    // Strobes while busy collapse into a single extra sweep.
    do_reset();
    base = valid_cnt;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
    end
    repeat (40) @(negedge clk);
    check_val("t5_valid_count", valid_cnt - base, 32'd2);

    // Reload in WAIT discards the in-flight word.
    do_reset();
    load_ch(0, 4'd4, 1'b0);
    fork
      sweep(16'h0000, lat);
      begin
        repeat (3) @(negedge clk);
        load[0] = 1'b1;
        instrument[3:0] = 4'd5;
        @(negedge clk);
        load = '0;
      end
    join
    check_val("t6_stale_addr", {24'd0, rom_addr}, 32'h40);
    sweep(16'h0003, lat);
    check_val("t6_new_addr", {24'd0, rom_addr}, 32'h50);

    // Step index wraps from 15 back to 0 within the instrument.
    do_reset();
    load_ch(3, 4'd6, 1'b0);
    for (int k = 0; k < 17; k++) sweep({4'(15 - (k % 16)), 12'h000}, lat);
    check_val("t7_wrap_addr", {24'd0, rom_addr}, 32'h60);

    // Asynchronous reset in the middle of a sweep.
    @(negedge clk);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_amp", {16'd0, amplitude}, 32'd0);
    check_val("midrst_addr", {24'd0, rom_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    check_val("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
